// File: rtl/alu_pkg.sv
// Shared ALU/MDU control encodings, the MDU state type and opcode-class helpers.
package alu_pkg;

   localparam logic [4:0] ALU_AND   = 5'b00000;
   localparam logic [4:0] ALU_OR    = 5'b00001;
   localparam logic [4:0] ALU_ADD   = 5'b00010;
   localparam logic [4:0] ALU_SLL   = 5'b00011;
   localparam logic [4:0] ALU_SRL   = 5'b00100;
   localparam logic [4:0] ALU_SUB   = 5'b00110;
   localparam logic [4:0] ALU_SLT   = 5'b00111;
   localparam logic [4:0] ALU_ADDU  = 5'b01000;
   localparam logic [4:0] ALU_SUBU  = 5'b01001;
   localparam logic [4:0] ALU_XOR   = 5'b01010;
   localparam logic [4:0] ALU_SLTU  = 5'b01011;
   localparam logic [4:0] ALU_NOR   = 5'b01100;
   localparam logic [4:0] ALU_SRA   = 5'b01101;
   localparam logic [4:0] ALU_LUI   = 5'b01110;
   localparam logic [4:0] ALU_MULT  = 5'b10000;
   localparam logic [4:0] ALU_MULTU = 5'b10001;
   localparam logic [4:0] ALU_DIV   = 5'b10010;
   localparam logic [4:0] ALU_DIVU  = 5'b10011;
   localparam logic [4:0] ALU_MFHI  = 5'b10100;
   localparam logic [4:0] ALU_MFLO  = 5'b10101;
   localparam logic [4:0] ALU_MTHI  = 5'b10110;
   localparam logic [4:0] ALU_MTLO  = 5'b10111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_ITER = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   function automatic logic is_md_op(input logic [4:0] ctrl);
      return (ctrl == ALU_MULT) || (ctrl == ALU_MULTU) ||
             (ctrl == ALU_DIV)  || (ctrl == ALU_DIVU);
   endfunction

   function automatic logic is_hilo_op(input logic [4:0] ctrl);
      return (ctrl == ALU_MFHI) || (ctrl == ALU_MFLO) ||
             (ctrl == ALU_MTHI) || (ctrl == ALU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide on operand magnitudes, with a final sign-fixup cycle.
// state   | meaning
// MD_IDLE | waiting for start; accepts operands
// MD_ITER | one product/quotient bit per cycle, WIDTH cycles
// MD_FIX  | apply signs, present result for the HI/LO write
import alu_pkg::*;

module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             res_we,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int SHW = $clog2(WIDTH);

   md_state_e        state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d, m_q, m_d, a_q, a_d;
   logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     div_shift, mul_sum;
   logic [2*WIDTH-1:0] prod, prod_fix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= MD_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_IDLE: if (start) state_d = MD_ITER;
         MD_ITER: if (cnt_q == '0) state_d = MD_FIX;
         MD_FIX:  state_d = MD_IDLE;
         default: state_d = MD_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != MD_IDLE);
      res_we = (state_q == MD_FIX);
   end

   assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
   assign div_shift = {p_hi_q, p_lo_q[WIDTH-1]};
   assign mul_sum   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, m_q} : '0);

   always_comb begin
      cnt_d  = cnt_q;
      p_hi_d = p_hi_q;
      p_lo_d = p_lo_q;
      m_d    = m_q;
      a_d    = a_q;
      div_d  = div_q;
      neg_d  = neg_q;
      rneg_d = rneg_q;
      dz_d   = dz_q;
      done_d = (state_q == MD_FIX);
      case (state_q)
         MD_IDLE: if (start) begin
            cnt_d  = SHW'(WIDTH - 1);
            p_hi_d = '0;
            p_lo_d = a_mag;
            m_d    = b_mag;
            a_d    = a;
            div_d  = is_div;
            neg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d = is_signed && a[WIDTH-1];
            dz_d   = is_div && (b == '0);
         end
         MD_ITER: begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (div_q) begin
               // restoring step: partial remainder stays below the divisor, so WIDTH bits suffice
               if (div_shift >= {1'b0, m_q}) begin
                  p_hi_d = div_shift[WIDTH-1:0] - m_q;
                  p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  p_hi_d = div_shift[WIDTH-1:0];
                  p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               p_hi_d = mul_sum[WIDTH:1];
               p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         p_hi_q <= '0;
         p_lo_q <= '0;
         m_q    <= '0;
         a_q    <= '0;
         div_q  <= 1'b0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         p_hi_q <= p_hi_d;
         p_lo_q <= p_lo_d;
         m_q    <= m_d;
         a_q    <= a_d;
         div_q  <= div_d;
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
         dz_q   <= dz_d;
         done_q <= done_d;
      end
   end

   assign prod     = {p_hi_q, p_lo_q};
   assign prod_fix = neg_q ? -prod : prod;

   always_comb begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
      if (div_q) begin
         if (dz_q) begin
            res_hi = a_q;
            res_lo = '1;
         end else begin
            res_hi = rneg_q ? -p_hi_q : p_hi_q;
            res_lo = neg_q  ? -p_lo_q : p_lo_q;
         end
      end
   end

   assign done = done_q;

endmodule

// File: rtl/alu_mdu.sv
// Combinational ALU with architectural HI/LO and an iterative multiply/divide unit behind a stall.
import alu_pkg::*;

module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             Reset_L,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic [4:0]       ALUCtrl,
   input  logic             MDStart,
   output logic [WIDTH-1:0] BusW,
   output logic             Zero,
   output logic             Overflow,
   output logic             Busy,
   output logic             Done,
   output logic             Stall
);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] md_hi, md_lo, add_sum, sub_diff, bus_w;
   logic             md_start, md_busy, md_done, md_we, ovf;
   logic [SHW-1:0]   shamt;

   assign md_start = MDStart && is_md_op(ALUCtrl);

   mdu_iter #(.WIDTH(WIDTH)) u_mdu (
      .clk       (CLK),
      .rst_n     (Reset_L),
      .start     (md_start),
      .is_div    (ALUCtrl[1]),
      .is_signed (~ALUCtrl[0]),
      .a         (BusA),
      .b         (BusB),
      .busy      (md_busy),
      .done      (md_done),
      .res_we    (md_we),
      .res_hi    (md_hi),
      .res_lo    (md_lo)
   );

   // MT writes cannot collide with the MDU result write: both need opposite Busy.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (md_we) begin
         hi_d = md_hi;
         lo_d = md_lo;
      end else if (MDStart && !md_busy) begin
         if (ALUCtrl == ALU_MTHI) hi_d = BusA;
         if (ALUCtrl == ALU_MTLO) lo_d = BusA;
      end
   end

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign shamt    = BusA[SHW-1:0];
   assign add_sum  = BusA + BusB;
   assign sub_diff = BusA - BusB;

   always_comb begin
      bus_w = '0;
      ovf   = 1'b0;
      case (ALUCtrl)
         ALU_AND:  bus_w = BusA & BusB;
         ALU_OR:   bus_w = BusA | BusB;
         ALU_XOR:  bus_w = BusA ^ BusB;
         ALU_NOR:  bus_w = ~(BusA | BusB);
         ALU_ADDU: bus_w = add_sum;
         ALU_SUBU: bus_w = sub_diff;
         ALU_ADD: begin
            bus_w = add_sum;
            ovf   = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (add_sum[WIDTH-1] != BusA[WIDTH-1]);
         end
         ALU_SUB: begin
            bus_w = sub_diff;
            ovf   = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (sub_diff[WIDTH-1] != BusA[WIDTH-1]);
         end
         ALU_SLL:  bus_w = BusB << shamt;
         ALU_SRL:  bus_w = BusB >> shamt;
         ALU_SRA:  bus_w = $signed(BusB) >>> shamt;
         ALU_SLT:  bus_w = {{(WIDTH-1){1'b0}}, $signed(BusA) < $signed(BusB)};
         ALU_SLTU: bus_w = {{(WIDTH-1){1'b0}}, BusA < BusB};
         ALU_LUI:  bus_w = BusB << (WIDTH / 2);
         ALU_MFHI: bus_w = hi_q;
         ALU_MFLO: bus_w = lo_q;
         default:  bus_w = '0;
      endcase
   end

   assign BusW     = bus_w;
   assign Zero     = (bus_w == '0);
   assign Overflow = ovf;
   assign Busy     = md_busy;
   assign Done     = md_done;
   assign Stall    = md_busy && (md_start || is_hilo_op(ALUCtrl));

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32.
import alu_pkg::*;

module tb_alu_mdu;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic [31:0] BusA, BusB, BusW;
   logic [4:0]  ALUCtrl;
   logic        MDStart, Zero, Overflow, Busy, Done, Stall;

   int errors = 0;
   int checks = 0;

   alu_mdu #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .Reset_L  (Reset_L),
      .BusA     (BusA),
      .BusB     (BusB),
      .ALUCtrl  (ALUCtrl),
      .MDStart  (MDStart),
      .BusW     (BusW),
      .Zero     (Zero),
      .Overflow (Overflow),
      .Busy     (Busy),
      .Done     (Done),
      .Stall    (Stall)
   );

   always #5 CLK = ~CLK;

   // called at a negedge; leaves the bench at the negedge after the accepting edge
   task automatic md_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      ALUCtrl = op;
      BusA    = a;
      BusB    = b;
      MDStart = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      MDStart = 1'b0;
      ALUCtrl = ALU_AND;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 100) begin
         n++;
         @(negedge CLK);
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
      ALUCtrl = ALU_MFHI;
      #1 hi = BusW;
      ALUCtrl = ALU_MFLO;
      #1 lo = BusW;
   endtask

   task automatic test_reset();
      logic [31:0] hi, lo;
      Reset_L = 1'b0;
      MDStart = 1'b0;
      ALUCtrl = ALU_AND;
      BusA = '0;
      BusB = '0;
      #12;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
      @(negedge CLK);
      Reset_L = 1'b1;
      @(negedge CLK);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall); end
      @(negedge CLK);
   endtask

   task automatic test_alu();
      logic [4:0]  v_op [17];
      logic [31:0] v_a [17], v_b [17], v_w [17];
      logic        v_ov [17], v_z [17];
      v_op[0]  = ALU_ADD;   v_a[0]  = 32'h7FFFFFFF; v_b[0]  = 32'h1;        v_w[0]  = 32'h80000000; v_ov[0]  = 1; v_z[0]  = 0;
      v_op[1]  = ALU_ADDU;  v_a[1]  = 32'h7FFFFFFF; v_b[1]  = 32'h1;        v_w[1]  = 32'h80000000; v_ov[1]  = 0; v_z[1]  = 0;
      v_op[2]  = ALU_SUB;   v_a[2]  = 32'h5;        v_b[2]  = 32'h5;        v_w[2]  = 32'h0;        v_ov[2]  = 0; v_z[2]  = 1;
      v_op[3]  = ALU_SUB;   v_a[3]  = 32'h80000000; v_b[3]  = 32'h1;        v_w[3]  = 32'h7FFFFFFF; v_ov[3]  = 1; v_z[3]  = 0;
      v_op[4]  = ALU_SUBU;  v_a[4]  = 32'h0;        v_b[4]  = 32'h1;        v_w[4]  = 32'hFFFFFFFF; v_ov[4]  = 0; v_z[4]  = 0;
      v_op[5]  = ALU_SRL;   v_a[5]  = 32'h21;       v_b[5]  = 32'h80000000; v_w[5]  = 32'h40000000; v_ov[5]  = 0; v_z[5]  = 0;
      v_op[6]  = ALU_SRA;   v_a[6]  = 32'h4;        v_b[6]  = 32'h80000000; v_w[6]  = 32'hF8000000; v_ov[6]  = 0; v_z[6]  = 0;
      v_op[7]  = ALU_SLL;   v_a[7]  = 32'h1F;       v_b[7]  = 32'h1;        v_w[7]  = 32'h80000000; v_ov[7]  = 0; v_z[7]  = 0;
      v_op[8]  = ALU_SLT;   v_a[8]  = 32'hFFFFFFFF; v_b[8]  = 32'h1;        v_w[8]  = 32'h1;        v_ov[8]  = 0; v_z[8]  = 0;
      v_op[9]  = ALU_SLTU;  v_a[9]  = 32'hFFFFFFFF; v_b[9]  = 32'h1;        v_w[9]  = 32'h0;        v_ov[9]  = 0; v_z[9]  = 1;
      v_op[10] = ALU_AND;   v_a[10] = 32'hF0F0;     v_b[10] = 32'hFF00;     v_w[10] = 32'hF000;     v_ov[10] = 0; v_z[10] = 0;
      v_op[11] = ALU_OR;    v_a[11] = 32'hF0F0;     v_b[11] = 32'hFF00;     v_w[11] = 32'hFFF0;     v_ov[11] = 0; v_z[11] = 0;
      v_op[12] = ALU_XOR;   v_a[12] = 32'hF0F0;     v_b[12] = 32'hFF00;     v_w[12] = 32'h0FF0;     v_ov[12] = 0; v_z[12] = 0;
      v_op[13] = ALU_NOR;   v_a[13] = 32'h0;        v_b[13] = 32'h0;        v_w[13] = 32'hFFFFFFFF; v_ov[13] = 0; v_z[13] = 0;
      v_op[14] = ALU_LUI;   v_a[14] = 32'h0;        v_b[14] = 32'h1234;     v_w[14] = 32'h12340000; v_ov[14] = 0; v_z[14] = 0;
      v_op[15] = 5'b00101;  v_a[15] = 32'h1;        v_b[15] = 32'h1;        v_w[15] = 32'h0;        v_ov[15] = 0; v_z[15] = 1;
      v_op[16] = ALU_ADD;   v_a[16] = 32'h80000000; v_b[16] = 32'h80000000; v_w[16] = 32'h0;        v_ov[16] = 1; v_z[16] = 1;
      for (int i = 0; i < 17; i++) begin
         ALUCtrl = v_op[i];
         BusA    = v_a[i];
         BusB    = v_b[i];
         #1;
         checks++; if (BusW !== v_w[i]) begin errors++; $display("FAIL alu[%0d]_busw got %h want %h", i, BusW, v_w[i]); end
         checks++; if (Overflow !== v_ov[i]) begin errors++; $display("FAIL alu[%0d]_ovf got %b want %b", i, Overflow, v_ov[i]); end
         checks++; if (Zero !== v_z[i]) begin errors++; $display("FAIL alu[%0d]_zero got %b want %b", i, Zero, v_z[i]); end
      end
      @(negedge CLK);
   endtask

   task automatic test_mult();
      int n;
      logic [31:0] hi, lo;
      md_issue(ALU_MULT, 32'hFFFFFFFD, 32'h5);
      wait_idle(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", n); end
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL mult_done got %b want 1", Done); end
      read_hilo(hi, lo);
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_hilo got %h/%h want ffffffff/fffffff1", hi, lo); end
      @(negedge CLK);
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", Done); end
      md_issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle(n);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_hilo got %h/%h want fffffffe/00000001", hi, lo); end
      @(negedge CLK);
   endtask

   task automatic test_div();
      int n;
      logic [31:0] hi, lo;
      md_issue(ALU_DIV, 32'hFFFFFFF9, 32'h2);
      wait_idle(n);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got %h/%h want ffffffff/fffffffd", hi, lo); end
      @(negedge CLK);
      md_issue(ALU_DIVU, 32'h9, 32'h0);
      wait_idle(n);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h9 || lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by0 got %h/%h want 00000009/ffffffff", hi, lo); end
      @(negedge CLK);
      md_issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'h80000000) begin errors++; $display("FAIL div_min_m1 got %h/%h want 00000000/80000000", hi, lo); end
      @(negedge CLK);
   endtask

   task automatic test_stall();
      int n;
      logic [31:0] hi, lo;
      md_issue(ALU_MTLO, 32'hCAFE, 32'h0);
      md_issue(ALU_MTHI, 32'hBEEF, 32'h0);
      read_hilo(hi, lo);
      checks++; if (hi !== 32'hBEEF || lo !== 32'hCAFE) begin errors++; $display("FAIL mt_write got %h/%h want 0000beef/0000cafe", hi, lo); end
      @(negedge CLK);
      md_issue(ALU_MULT, 32'h6, 32'h7);
      ALUCtrl = ALU_MFLO;
      #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL mflo_stall got %b want 1", Stall); end
      checks++; if (BusW !== 32'hCAFE) begin errors++; $display("FAIL mflo_old_lo got %h want 0000cafe", BusW); end
      ALUCtrl = ALU_MULT;
      BusA = 32'd100;
      BusB = 32'd100;
      MDStart = 1'b1;
      #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL mult_reissue_stall got %b want 1", Stall); end
      @(posedge CLK);
      @(negedge CLK);
      ALUCtrl = ALU_MTHI;
      BusA = 32'h5555;
      #1;
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall got %b want 1", Stall); end
      @(posedge CLK);
      @(negedge CLK);
      MDStart = 1'b0;
      ALUCtrl = ALU_ADD;
      BusA = 32'd2;
      BusB = 32'd3;
      #1;
      checks++; if (BusW !== 32'd5 || Stall !== 1'b0) begin errors++; $display("FAIL add_while_busy got %h stall %b want 00000005 stall 0", BusW, Stall); end
      wait_idle(n);
      checks++; if (n !== 31) begin errors++; $display("FAIL stall_busy_rest got %0d want 31", n); end
      checks++; if (Done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", Done); end
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'd42) begin errors++; $display("FAIL stall_result got %h/%h want 00000000/0000002a", hi, lo); end
      ALUCtrl = ALU_MTHI;
      BusA = 32'h1234;
      MDStart = 1'b1;
      #1;
      checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL mthi_done_stall got %b want 0", Stall); end
      @(posedge CLK);
      @(negedge CLK);
      MDStart = 1'b0;
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h1234 || lo !== 32'd42) begin errors++; $display("FAIL mthi_done_write got %h/%h want 00001234/0000002a", hi, lo); end
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      int n;
      logic [31:0] hi, lo;
      md_issue(ALU_MULTU, 32'd3, 32'd4);
      wait_idle(n);
      read_hilo(hi, lo);
      checks++; if (lo !== 32'd12 || Done !== 1'b1) begin errors++; $display("FAIL b2b_first got %h done %b want 0000000c done 1", lo, Done); end
      md_issue(ALU_MULTU, 32'd5, 32'd6);
      wait_idle(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 33", n); end
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'd30) begin errors++; $display("FAIL b2b_second got %h/%h want 00000000/0000001e", hi, lo); end
      @(negedge CLK);
   endtask

   task automatic test_reset_mid_op();
      int n;
      logic [31:0] hi, lo;
      md_issue(ALU_DIV, 32'd1000, 32'd3);
      repeat (9) @(negedge CLK);
      Reset_L = 1'b0;
      #1;
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", Busy); end
      read_hilo(hi, lo);
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h/%h want 0/0", hi, lo); end
      repeat (2) @(negedge CLK);
      checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", Done); end
      Reset_L = 1'b1;
      @(negedge CLK);
      checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL midrst_release got done %b busy %b want 0/0", Done, Busy); end
      md_issue(ALU_DIVU, 32'd100, 32'd7);
      wait_idle(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL postrst_busy_cycles got %0d want 33", n); end
      read_hilo(hi, lo);
      checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL postrst_divu got %h/%h want 00000002/0000000e", hi, lo); end
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mult();
      test_div();
      test_stall();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the datapath ALU. It adds an iterative multiply/divide unit with architectural HI/LO registers. It also adds signed-overflow detection and correctly masked shift amounts. Single-cycle ops stay combinational on BusW. MULT/DIV run over multiple cycles with a start/busy/done handshake, and the unit raises Stall to the pipeline hazard unit.

Parameters:
WIDTH, 32, datapath width in bits; must be a power of two, at least 8.
SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset_L  in  1  asynchronous active-low reset
BusA  in  WIDTH  operand A (rs; shift amount for shifts)
BusB  in  WIDTH  operand B (rt)
ALUCtrl  in  5  operation select; encodings from alu_pkg
MDStart  in  1  issue qualifier for MULT/MULTU/DIV/DIVU/MTHI/MTLO
BusW  out  WIDTH  result
Zero  out  1  BusW == 0
Overflow  out  1  signed overflow on ADD/SUB only; 0 for all other ops
Busy  out  1  multiply/divide in progress
Done  out  1  one-cycle pulse; HI/LO updated on the preceding edge
Stall  out  1  issue or HI/LO access blocked by Busy

Behaviour:
- Reset (async, Reset_L=0): HI=0, LO=0, Busy=0, Done=0, iteration counter=0. Any in-flight op is abandoned. BusW, Zero, Overflow and Stall are combinational and follow their inputs.
- Single-cycle ops (ALUCtrl[4]=0) are combinational, with codes 0x0–0xE as in alu_pkg:
  - AND, OR, XOR, NOR, ADD, ADDU, SUB, SUBU behave as usual.
  - ADD/SUB Overflow = operand signs equal (B inverted for SUB) and result sign differs. ADDU/SUBU never flag. BusW is always the wrapped sum.
  - SLL, SRL, SRA shift BusB by BusA[SHW-1:0]; upper bits of BusA are ignored.
  - SLT is a signed compare; SLTU is an unsigned compare; result is 0 or 1, zero-extended.
  - LUI = BusB << (WIDTH/2).
  - Undefined codes give BusW=0.
- HI/LO reads are combinational: MFHI gives BusW=HI, MFLO gives BusW=LO.
- HI/LO writes: MTHI/MTLO write BusA into HI/LO on the edge where MDStart=1 and Busy=0.
- MD ops (MULT, MULTU, DIV, DIVU) are accepted on the edge where MDStart=1 and Busy=0. Operands and op are latched and Busy=1 from the next cycle.
  - Radix-2 iteration: one bit per cycle for WIDTH cycles, then one sign-fixup cycle.
  - HI/LO are written on the (WIDTH+1)th edge after acceptance. Busy falls on that same edge and Done=1 for the following cycle.
  - Latency is WIDTH+1 cycles; back-to-back issue is allowed in the Done cycle.
- Signed ops work on magnitudes; the result is negated at fixup. Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- MULT/MULTU: {HI,LO} = full 2*WIDTH product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Divide by zero: LO = all ones, HI = BusA.
  - DIV of MIN by -1: LO = MIN, HI = 0. No exception is raised.
- Stall = Busy AND (MD op with MDStart, or ALUCtrl in MFHI/MFLO/MTHI/MTLO).
  - While Stall=1, a new MD/MT issue is ignored: no state change and no restart.
  - MFHI/MFLO still drive the old HI/LO; the pipeline must hold.
- While Busy, single-cycle ALU ops proceed unaffected.
- If Reset_L is asserted mid-operation, HI/LO are cleared, not left partial. The first issue after release behaves like the first issue after power-up.

Decomposition:
- alu_pkg holds:
  - the 5-bit ALUCtrl localparams: AND 00000, OR 00001, ADD 00010, SLL 00011, SRL 00100, SUB 00110, SLT 00111, ADDU 01000, SUBU 01001, XOR 01010, SLTU 01011, NOR 01100, SRA 01101, LUI 01110, MULT 10000, MULTU 10001, DIV 10010, DIVU 10011, MFHI 10100, MFLO 10101, MTHI 10110, MTLO 10111;
  - an is_md_op function.
- One sub-module, mdu_iter, contains the shift/add-subtract datapath, counter, and sign fixup, with its start/busy/done handshake. alu_mdu holds the combinational ALU, HI/LO, and Stall.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF + 0x00000001 -> BusW=0x80000000, Overflow=1, Zero=0. ADDU with the same operands -> Overflow=0. SUB 0x5 - 0x5 -> Zero=1.
- SRL, BusB=0x80000000, BusA=0x00000021 -> shift by 1, BusW=0x40000000. SRA, BusB=0x80000000, BusA=4 -> 0xF8000000. SLT -1 vs 1 -> 1; SLTU -> 0.
- MULT A=-3, B=5 with MDStart pulse -> Busy for 33 cycles, Done pulse, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 9 / 0 -> LO=0xFFFFFFFF, HI=0x00000009. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- During MULT: MFLO -> Stall=1, BusW=old LO. A second MULT with MDStart -> Stall=1 and is ignored (final result is from the first op). In the Done cycle, MTHI 0x1234 -> HI=0x1234 on the next edge.
- Start DIV, assert Reset_L=0 at iteration 10 -> Busy=0, HI=LO=0, no Done. Release reset, issue DIVU 100/7 -> LO=14, HI=2 after 33 cycles.
